// File: rtl/alu_defs.sv
// Shared ALU definitions: opcodes, flag bit positions and condition codes.
package alu_defs;

   // ALU opcodes used by the decode/execute path
   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_CMP = 3'd5,
      ALU_MOV = 3'd6,
      ALU_NOP = 3'd7
   } alu_op_e;

   // Bit positions inside a 2-bit flag vector {N,Z}
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;

   // Condition codes evaluated against the stored flags
   localparam logic [2:0] COND_AL = 3'b000;
   localparam logic [2:0] COND_EQ = 3'b001;
   localparam logic [2:0] COND_NE = 3'b010;
   localparam logic [2:0] COND_LT = 3'b011;
   localparam logic [2:0] COND_GE = 3'b100;
   localparam logic [2:0] COND_GT = 3'b101;
   localparam logic [2:0] COND_LE = 3'b110;
   localparam logic [2:0] COND_NV = 3'b111;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: does cond pass for the given {N,Z} flags.
module cond_check
   import alu_defs::*;
(
   input  logic [2:0] cond,
   input  logic [1:0] flags,
   output logic       pass
);

   logic z;
   logic n;

   assign z = flags[FLAG_Z];
   assign n = flags[FLAG_N];

   // Decode the condition code into a single pass bit
   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_AL: pass = 1'b1;
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_LT: pass = n;
         COND_GE: pass = ~n;
         COND_GT: pass = ~z & ~n;
         COND_LE: pass = z | n;
         COND_NV: pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with conditional execution and the architectural
// flag register. Conditions are judged against the stored flags, so a
// flag-setting instruction affects only the instructions behind it.
module ex_mem_stage
   import alu_defs::*;
#(
   parameter int N = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         stall_i,
   input  logic         flush_i,
   input  logic         valid_i,
   input  logic [N-1:0] alu_result_i,
   input  logic [1:0]   alu_flags_i,
   input  logic [N-1:0] write_data_i,
   input  logic [3:0]   rd_i,
   input  logic [2:0]   cond_i,
   input  logic         flag_write_i,
   input  logic         reg_write_i,
   input  logic         mem_write_i,
   input  logic         mem_to_reg_i,
   input  logic         pc_src_i,
   output logic         valid_o,
   output logic [N-1:0] alu_result_o,
   output logic [N-1:0] write_data_o,
   output logic [3:0]   rd_o,
   output logic         reg_write_o,
   output logic         mem_write_o,
   output logic         mem_to_reg_o,
   output logic         pc_src_o,
   output logic [1:0]   flags_o,
   output logic         cond_ex_o
);

   logic cond_pass;

   cond_check u_cond_check (
      .cond  (cond_i),
      .flags (flags_o),
      .pass  (cond_pass)
   );

   // Instruction in EX actually executes: live, condition true, not killed
   assign cond_ex_o = valid_i & cond_pass & ~flush_i;

   // Stage registers: reset beats flush, flush beats stall, stall holds all
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_o      <= 1'b0;
         alu_result_o <= '0;
         write_data_o <= '0;
         rd_o         <= '0;
         reg_write_o  <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_to_reg_o <= 1'b0;
         pc_src_o     <= 1'b0;
         flags_o      <= 2'b00;
      end else if (flush_i) begin
         // Data outputs are left as-is; nothing downstream looks at them
         // while valid_o is low.
         valid_o      <= 1'b0;
         reg_write_o  <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_to_reg_o <= 1'b0;
         pc_src_o     <= 1'b0;
      end else if (!stall_i) begin
         valid_o      <= valid_i;
         alu_result_o <= alu_result_i;
         write_data_o <= write_data_i;
         rd_o         <= rd_i;
         reg_write_o  <= reg_write_i & cond_ex_o;
         mem_write_o  <= mem_write_i & cond_ex_o;
         pc_src_o     <= pc_src_i & cond_ex_o;
         // Not condition-gated, but a bubble must still carry no controls
         mem_to_reg_o <= mem_to_reg_i & valid_i;
         if (flag_write_i & cond_ex_o)
            flags_o <= alu_flags_i;
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus randomized traffic checked
// against a transaction-level model of the stage.
module tb_ex_mem_stage;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst, stall, flush, valid;
   logic [N-1:0] alu_res, wdata;
   logic [1:0]   alu_flags;
   logic [3:0]   rd;
   logic [2:0]   cond;
   logic         fw, rw, mw, m2r, pcs;

   logic         valid_o, reg_write_o, mem_write_o, mem_to_reg_o, pc_src_o, cond_ex_o;
   logic [N-1:0] alu_result_o, write_data_o;
   logic [3:0]   rd_o;
   logic [1:0]   flags_o;

   int checks = 0;
   int errors = 0;

   // model state
   bit           m_valid, m_rw, m_mw, m_m2r, m_pc, m_dknown;
   logic [N-1:0] m_res, m_wd;
   logic [3:0]   m_rd;
   logic [1:0]   m_flags;

   ex_mem_stage #(.N(N)) dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
      .alu_result_i(alu_res), .alu_flags_i(alu_flags), .write_data_i(wdata),
      .rd_i(rd), .cond_i(cond), .flag_write_i(fw), .reg_write_i(rw),
      .mem_write_i(mw), .mem_to_reg_i(m2r), .pc_src_i(pcs),
      .valid_o(valid_o), .alu_result_o(alu_result_o), .write_data_o(write_data_o),
      .rd_o(rd_o), .reg_write_o(reg_write_o), .mem_write_o(mem_write_o),
      .mem_to_reg_o(mem_to_reg_o), .pc_src_o(pc_src_o), .flags_o(flags_o),
      .cond_ex_o(cond_ex_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Condition truth table written out per flag combination (index = {N,Z})
   function automatic bit cond_ok(input logic [2:0] c, input logic [1:0] f);
      bit [3:0] mask [8];
      mask[0] = 4'b1111; // AL
      mask[1] = 4'b1010; // EQ : Z
      mask[2] = 4'b0101; // NE : !Z
      mask[3] = 4'b1100; // LT : N
      mask[4] = 4'b0011; // GE : !N
      mask[5] = 4'b0001; // GT : neither
      mask[6] = 4'b1110; // LE : either
      mask[7] = 4'b0000; // NV
      return mask[c][f];
   endfunction

   task automatic set_idle();
      rst = 0; stall = 0; flush = 0; valid = 0; alu_res = '0; wdata = '0;
      alu_flags = 2'b00; rd = '0; cond = 3'b000; fw = 0; rw = 0; mw = 0; m2r = 0; pcs = 0;
   endtask

   // One clock: check cond_ex_o before the edge, advance the model, compare after
   task automatic cycle();
      bit ex;
      #1;
      ex = valid && cond_ok(cond, m_flags) && !flush;
      check("cond_ex", cond_ex_o, ex);
      @(posedge clk);
      if (rst) begin
         m_valid = 0; m_rw = 0; m_mw = 0; m_m2r = 0; m_pc = 0;
         m_res = '0; m_wd = '0; m_rd = '0; m_flags = 2'b00; m_dknown = 1;
      end else if (flush) begin
         m_valid = 0; m_rw = 0; m_mw = 0; m_m2r = 0; m_pc = 0; m_dknown = 0;
      end else if (!stall) begin
         m_valid = valid; m_res = alu_res; m_wd = wdata; m_rd = rd; m_dknown = 1;
         m_rw = rw && ex; m_mw = mw && ex; m_pc = pcs && ex; m_m2r = m2r && valid;
         if (fw && ex) m_flags = alu_flags;
      end
      #1;
      check("valid", valid_o, m_valid);
      check("reg_write", reg_write_o, m_rw);
      check("mem_write", mem_write_o, m_mw);
      check("mem_to_reg", mem_to_reg_o, m_m2r);
      check("pc_src", pc_src_o, m_pc);
      check("flags", flags_o, m_flags);
      if (m_dknown) begin
         check("alu_result", alu_result_o, m_res);
         check("write_data", write_data_o, m_wd);
         check("rd", rd_o, m_rd);
      end
   endtask

   initial begin
      m_flags = 2'b00; m_dknown = 0;
      m_valid = 0; m_rw = 0; m_mw = 0; m_m2r = 0; m_pc = 0;
      m_res = '0; m_wd = '0; m_rd = '0;
      set_idle();

      // Reset with every input high
      rst = 1; stall = 1; flush = 1; valid = 1; alu_res = '1; wdata = '1; alu_flags = 2'b11;
      rd = '1; cond = 3'b111; fw = 1; rw = 1; mw = 1; m2r = 1; pcs = 1;
      cycle();
      check("rst_valid", valid_o, 0);
      check("rst_res", alu_result_o, 0);
      check("rst_flags", flags_o, 0);
      check("rst_rd", rd_o, 0);

      // CMP sets Z, then BEQ takes the branch
      set_idle();
      valid = 1; alu_flags = 2'b01; fw = 1; cond = 3'b000;
      cycle();
      check("cmp_flags", flags_o, 2'b01);
      set_idle();
      valid = 1; pcs = 1; cond = 3'b001; alu_flags = 2'b10;
      cycle();
      check("beq_pc_src", pc_src_o, 1);

      // Failed condition: clear flags first, then EQ must not execute
      set_idle();
      valid = 1; fw = 1; alu_flags = 2'b00;
      cycle();
      set_idle();
      valid = 1; cond = 3'b001; rw = 1; alu_res = 4'hA; fw = 1; alu_flags = 2'b11;
      cycle();
      check("nc_valid", valid_o, 1);
      check("nc_reg_write", reg_write_o, 0);
      check("nc_res", alu_result_o, 4'hA);
      check("nc_flags", flags_o, 2'b00);

      // Stall holds everything for 3 cycles
      set_idle();
      valid = 1; alu_res = 4'h5; rw = 1;
      cycle();
      stall = 1; alu_res = 4'h9; fw = 1; alu_flags = 2'b10;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("stall_res", alu_result_o, 4'h5);
         check("stall_flags", flags_o, 2'b00);
      end

      // Flush together with stall behaves as a flush
      set_idle();
      flush = 1; stall = 1; valid = 1; rw = 1; fw = 1; alu_flags = 2'b11;
      cycle();
      check("fs_valid", valid_o, 0);
      check("fs_reg_write", reg_write_o, 0);
      check("fs_flags", flags_o, 2'b00);

      // Reset during a stall clears the held instruction
      set_idle();
      valid = 1; rw = 1; alu_res = 4'h3;
      cycle();
      stall = 1; rst = 1;
      cycle();
      check("rst_stall_valid", valid_o, 0);

      // Every condition against every stored flag value
      for (int f = 0; f < 4; f++) begin
         set_idle();
         valid = 1; fw = 1; alu_flags = f[1:0];
         cycle();
         set_idle();
         valid = 1;
         for (int c = 0; c < 8; c++) begin
            cond = c[2:0];
            #1;
            check($sformatf("cond_table_c%0d_f%0d", c, f), cond_ex_o, cond_ok(c[2:0], f[1:0]));
         end
      end
      set_idle();
      valid = 1; fw = 1; alu_flags = 2'b00; cycle();
      set_idle(); valid = 1; cond = 3'b101; #1;
      check("gt_flags00", cond_ex_o, 1);
      set_idle();
      valid = 1; fw = 1; alu_flags = 2'b10; cycle();
      set_idle(); valid = 1; cond = 3'b110; #1;
      check("le_flags10", cond_ex_o, 1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 39) == 0);
         stall     = ($urandom_range(0, 5) == 0);
         flush     = ($urandom_range(0, 7) == 0);
         valid     = ($urandom_range(0, 3) != 0);
         alu_res   = N'($urandom);
         wdata     = N'($urandom);
         alu_flags = 2'($urandom);
         rd        = 4'($urandom);
         cond      = 3'($urandom);
         fw        = 1'($urandom);
         rw        = 1'($urandom);
         mw        = 1'($urandom);
         m2r       = 1'($urandom);
         pcs       = 1'($urandom);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter: N, default 4, datapath width; SHALL match the ALU width.
REQ-002 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  in  1  reset; SHALL be synchronous and active-high.
REQ-004 stall_i  in  1  hold all stage state.
REQ-005 flush_i  in  1  kill the instruction currently in EX.
REQ-006 valid_i  in  1  EX holds a live instruction.
REQ-007 alu_result_i  in  N  ALU result.
REQ-008 alu_flags_i  in  2  ALU flags: [0]=Z, [1]=N.
REQ-009 write_data_i  in  N  store data.
REQ-010 rd_i  in  4  destination register index.
REQ-011 cond_i  in  3  condition code.
REQ-012 flag_write_i, reg_write_i, mem_write_i, mem_to_reg_i, pc_src_i  in  1 each  decoded controls.
REQ-013 valid_o  out  1  MEM stage holds a live instruction.
REQ-014 alu_result_o, write_data_o  out  N each  registered data.
REQ-015 rd_o  out  4  registered destination.
REQ-016 reg_write_o, mem_write_o, mem_to_reg_o, pc_src_o  out  1 each  registered, condition-gated controls.
REQ-017 flags_o  out  2  architectural flag register {N,Z}.
REQ-018 cond_ex_o  out  1  combinational: EX instruction executes (to hazard unit).

Function
REQ-019 Conditions SHALL be evaluated against flags_o (the stored flags), not alu_flags_i.
REQ-020 Encodings: AL=000 true; EQ=001 Z; NE=010 !Z; LT=011 N; GE=100 !N; GT=101 !Z&!N; LE=110 Z|N; NV=111 false.
REQ-021 cond_ex_o SHALL equal valid_i & condition-pass & !flush_i.
REQ-022 When !stall_i and !flush_i, the stage SHALL capture all data inputs and set valid_o<=valid_i on the next edge, a latency of 1 cycle.
REQ-023 The registered reg_write, mem_write and pc_src SHALL be the input controls ANDed with cond_ex_o; mem_to_reg_o SHALL pass ungated.
REQ-024 flags_o SHALL load alu_flags_i only when flag_write_i & cond_ex_o & !stall_i.
REQ-025 stall_i=1 SHALL hold every register, including flags_o, unchanged.
REQ-026 flush_i=1 SHALL, on the next edge, clear valid_o and all control outputs to 0, leave flags_o unchanged, and leave the data outputs don't-care.
REQ-027 Simultaneous flush_i and stall_i SHALL resolve as a flush.
REQ-028 valid_i=0 SHALL produce valid_o=0 with all controls 0 on the next edge, unless stalled.
REQ-029 Data SHALL pass without width change or arithmetic; no wrap or overflow handling is performed.

Reset
REQ-030 rst_i SHALL take priority over stall_i and flush_i.
REQ-031 On reset, valid_o, all control outputs, alu_result_o, write_data_o, rd_o and flags_o SHALL be 0.
REQ-032 A reset asserted mid-stall SHALL clear the held instruction on that edge.

Structure
REQ-033 The condition-code constants SHALL be added to the shared package alu_defs, alongside the ALU opcodes.
REQ-034 Condition evaluation SHALL be a combinational sub-module cond_check (inputs cond, flags; output pass).
REQ-035 All registers SHALL reside in ex_mem_stage.

Verification
REQ-036 Reset test: set rst_i=1 with all inputs high -> after 1 edge, all outputs are 0 and flags_o=00.
REQ-037 Flag path, N=4: CMP with alu_flags_i=01, flag_write_i=1, cond AL -> flags_o=01; then BEQ with pc_src_i=1, cond EQ -> pc_src_o=1 next cycle.
REQ-038 Failed condition: flags_o=00, cond EQ, reg_write_i=1, alu_result_i=4'hA -> valid_o=1, reg_write_o=0, alu_result_o=4'hA, flags_o unchanged.
REQ-039 Stall: capture 4'h5, then hold stall_i=1 for 3 cycles while inputs change to 4'h9 with flag_write -> alu_result_o stays 4'h5 and flags_o is constant.
REQ-040 Flush with stall: flush_i=stall_i=1, valid_i=1, reg_write_i=1, flag_write_i=1 -> valid_o=0, reg_write_o=0, flags_o unchanged.
REQ-041 Exhaustive check of cond_check: all 8 conds x 4 flag values -> matches the REQ-020 table, e.g. GT with flags 00 passes and LE with flags 10 passes.
